// File: rtl/ft600_fifo_responder_pkg.sv
// ft600_pkg: shared widths, burst FSM encoding and frame constants for the FT600 responder
package ft600_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BE_W = 2;
    localparam int FRAME_WORDS = 256;
    localparam logic [15:0] BE_ALL = '1;
    typedef enum logic {IDLE, BURST} burst_state_t;
endpackage

// File: rtl/ft600_fifo_responder_sync_fifo.sv
// sync_fifo: power-of-two FIFO with a registered show-ahead head word
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [AW:0]      count,
    output logic [AW:0]      count_nxt,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    // head is loaded with whatever will sit at the read pointer after this edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_nxt;
            if (push && count == (AW+1)'(pop)) head <= wdata;
            else if (count > (AW+1)'(pop)) head <= mem[rd_ptr + AW'(pop)];
        end
endmodule

// File: rtl/ft600_fifo_responder.sv
// ft600_fifo_responder: FT600 245-sync-FIFO device side with command injection and capture streams
module ft600_fifo_responder
    import ft600_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W = DEF_BE_W,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 2 * FRAME_WORDS
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   TXE_N,
    output logic                   RXF_N,
    input  logic                   OE_N,
    input  logic                   RD_N,
    input  logic                   WR_N,
    inout  wire  [DATA_W-1:0]      DATA,
    inout  wire  [BE_W-1:0]        BE,
    input  logic                   cmd_valid,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic                   cmd_ready,
    input  logic                   tx_hold,
    output logic                   cap_valid,
    output logic [DATA_W+BE_W-1:0] cap_data,
    input  logic                   cap_ready,
    output logic                   burst_done,
    output logic [15:0]            burst_len,
    output logic                   err_overflow,
    output logic                   err_underflow
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    logic [RAW:0] rx_count, rx_cnt_nxt;
    logic [TAW:0] tx_count, tx_cnt_nxt;
    logic [DATA_W-1:0] rx_head;
    logic rx_push, rx_pop, tx_push, tx_pop;
    burst_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt, len_nxt;
    logic done_nxt;
    assign cmd_ready = rx_count != (RAW+1)'(RX_DEPTH);
    assign rx_push = cmd_valid && cmd_ready;
    assign rx_pop = !OE_N && !RD_N && !RXF_N;
    assign tx_push = !WR_N && !TXE_N;
    assign tx_pop = cap_valid && cap_ready;
    assign cap_valid = tx_count != '0;
    assign DATA = OE_N ? {DATA_W{1'bz}} : (RXF_N ? '0 : rx_head);
    assign BE = OE_N ? {BE_W{1'bz}} : BE_ALL[BE_W-1:0];
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(cmd_data),
        .count(rx_count), .count_nxt(rx_cnt_nxt), .head(rx_head)
    );
    sync_fifo #(.WIDTH(DATA_W+BE_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata({BE, DATA}),
        .count(tx_count), .count_nxt(tx_cnt_nxt), .head(cap_data)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            TXE_N         <= 1'b1;
            RXF_N         <= 1'b1;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            TXE_N         <= tx_cnt_nxt == (TAW+1)'(TX_DEPTH) || tx_hold;
            RXF_N         <= rx_cnt_nxt == '0;
            err_overflow  <= err_overflow | (!WR_N && TXE_N);
            err_underflow <= err_underflow | (!RD_N && !OE_N && RXF_N);
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            burst_len  <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            burst_len  <= len_nxt;
            burst_done <= done_nxt;
        end
    // dropped strobes still open and extend a burst, they just do not count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = burst_len;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (!WR_N) begin
                state_nxt = BURST;
                cnt_nxt   = 16'(tx_push);
            end
        end else if (!WR_N) begin
            cnt_nxt = (tx_push && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
        end else begin
            state_nxt = IDLE;
            len_nxt   = cnt;
            done_nxt  = 1'b1;
        end
    end
endmodule
